axi_mem_loader: RTL and testbench
=================================

AXI_MEM_LOADER -- requirements
Module: axi_mem_loader

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: the clock is `clk`, the reset is `rst`, and all logic is clocked on the rising edge of `clk`.
REQ-002 Parameters (name, default, meaning) SHALL be:
- DATA_WIDTH, 64, AXI data width.
- ADDR_WIDTH, 16, AXI address width.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant value driven on awid/arid.
- STRB_WIDTH, DATA_WIDTH/8, byte lanes.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- cmd_addr, in, ADDR_WIDTH, burst start byte address.
- cmd_len, in, 8, beats minus one.
- cmd_write, in, 1, 1 = write burst, 0 = read burst.
- cmd_valid / cmd_ready, in / out, 1 each, command handshake.
- s_wr_data, in, DATA_WIDTH, write beat data.
- s_wr_valid / s_wr_ready, in / out, 1 each, write-data stream handshake.
- m_rd_data, out, DATA_WIDTH, read beat data.
- m_rd_last, out, 1, final read beat.
- m_rd_valid / m_rd_ready, out / in, 1 each, read-data stream handshake.
- done, out, 1, one-cycle completion pulse.
- error, out, 1, error status, valid when done=1.
- m_axi_aw{id, addr, len, size, burst, lock, cache, prot, valid}, out, ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1, AXI4 write address channel.
- m_axi_awready, in, 1.
- m_axi_w{data, strb, last, valid}, out, DATA_WIDTH/STRB_WIDTH/1/1, AXI4 write data channel.
- m_axi_wready, in, 1.
- m_axi_b{id, resp, valid}, in, ID_WIDTH/2/1.
- m_axi_bready, out, 1.
- m_axi_ar{id, addr, len, size, burst, lock, cache, prot, valid}, out, same widths as aw, AXI4 read address channel.
- m_axi_arready, in, 1.
- m_axi_r{id, data, resp, last, valid}, in, ID_WIDTH/DATA_WIDTH/2/1/1.
- m_axi_rready, out, 1.

Function
REQ-004 The FSM SHALL have states IDLE, AW, W, B, AR, R, and SHALL handle one command at a time.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready, and then latches addr, len and write.
REQ-006 After acceptance the FSM SHALL move IDLE->AW if write=1, otherwise IDLE->AR, on the next cycle.
REQ-007 Constant fields SHALL be: awid/arid=AXI_ID; awlen/arlen=latched len; awsize/arsize=log2(STRB_WIDTH); burst=2'b01 (INCR); lock=0; cache=4'b0011; prot=3'b000; wstrb all ones.
REQ-008 AW/AR valid SHALL be asserted throughout state AW/AR and held with stable fields until ready; the handshake moves AW->W or AR->R.
REQ-009 In state W, m_axi_wvalid SHALL equal s_wr_valid, s_wr_ready SHALL equal m_axi_wready, and wdata SHALL pass through combinationally.
REQ-010 An 8-bit beat counter SHALL reset to 0 on command acceptance and increment on each W or R handshake.
REQ-011 wlast SHALL be 1 when counter==len; the final W handshake moves W->B.
REQ-012 In state B, bready SHALL be 1; the B handshake returns the FSM to IDLE, pulses done, and sets error=(bresp!=2'b00).
REQ-013 In state R, rready SHALL equal m_rd_ready, m_rd_valid SHALL equal rvalid, m_rd_data SHALL equal rdata, and m_rd_last SHALL equal (counter==len).
REQ-014 Read error SHALL be sticky across a burst: it is set by any beat with rresp!=0, or by rlast mismatching (counter==len).
REQ-015 On an R handshake with rlast=1, the FSM SHALL return to IDLE and pulse done with the accumulated error; an early rlast ends the burst with error=1.
REQ-016 On an R handshake with counter==len but rlast=0, the FSM SHALL still finish with error=1 and SHALL NOT wait for further beats.
REQ-017 In state R, extra rvalid beats arriving after the FSM leaves R SHALL be ignored (rready=0 outside R).
REQ-018 cmd_len=0 SHALL produce a single beat with wlast=1 (or m_rd_last=1).
REQ-019 cmd_valid asserted in a non-IDLE state SHALL be held off (cmd_ready=0).
REQ-020 A new command SHALL be accepted no earlier than the cycle after done.
REQ-021 s_wr_ready SHALL be 0 outside W, and m_rd_valid SHALL be 0 outside R.
REQ-022 done and error SHALL be registered; error SHALL hold its value until the next done.

Reset
REQ-023 Asserting rst, including mid-burst, SHALL immediately force: FSM=IDLE, every *valid, *ready and done output to 0, error=0, counter=0, and cmd_ready=0 while rst is high.
REQ-024 The first command after reset release SHALL start a fresh burst.

Verification
REQ-025 Write of len=3 at 0x0100 with the slave always ready -> awlen=3, awsize=3, exactly 4 W beats, wlast only on beat 4, done 1 cycle after the B handshake, error=0.
REQ-026 Read of len=7 at 0x0200 with m_rd_ready toggling 50% -> 8 beats delivered in order, m_rd_last only on beat 8, no beat lost or duplicated.
REQ-027 Write with bresp=2'b10 -> done=1 with error=1; a following read with rresp=0 -> error=0.
REQ-028 Read len=3 where the slave drives rlast on beat 2 -> done after beat 2 with error=1, FSM in IDLE.
REQ-029 rst asserted during beat 2 of a len=5 write -> wvalid and awvalid drop asynchronously, cmd_ready=1 after release, and the next len=0 write completes normally.
REQ-030 Write with s_wr_valid stalled 10 cycles between beats and awready delayed 5 cycles -> awaddr stable until accepted, wvalid=0 during stalls, and data matches the source stream.

Source files
------------

// File: rtl/axi_mem_loader_if.sv
// ============================================================================
// axi_mem_loader_if : command, stream and AXI4 master bundle for axi_mem_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axi_mem_loader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  cmd_write;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] s_wr_data;
    logic                  s_wr_valid;
    logic                  s_wr_ready;
    logic [DATA_WIDTH-1:0] m_rd_data;
    logic                  m_rd_last;
    logic                  m_rd_valid;
    logic                  m_rd_ready;
    logic                  done;
    logic                  error;

    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_addr, cmd_len, cmd_write, cmd_valid,
        output cmd_ready,
        input  s_wr_data, s_wr_valid,
        output s_wr_ready,
        output m_rd_data, m_rd_last, m_rd_valid,
        input  m_rd_ready,
        output done, error,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_write, cmd_valid,
        input  cmd_ready,
        output s_wr_data, s_wr_valid,
        input  s_wr_ready,
        input  m_rd_data, m_rd_last, m_rd_valid,
        output m_rd_ready,
        input  done, error,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

`default_nettype wire

// File: rtl/axi_mem_loader.sv
// ============================================================================
// axi_mem_loader : single-outstanding AXI4 burst engine bridging streams to memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_mem_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  wire              clk,
    input  wire              rst,
    axi_mem_loader_if.master bus
);
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  rd_err_q, rd_err_d;

    logic last_beat;
    logic cmd_fire;
    logic w_fire;
    logic r_fire;
    logic r_beat_err;
    logic w_unused_ok;

    assign last_beat  = (cnt_q == len_q);
    // Holding off in the done cycle guarantees a gap before the next command.
    assign bus.cmd_ready = (state_q == S_IDLE) && !done_q && !rst;
    assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
    assign w_fire     = bus.m_axi_wvalid && bus.m_axi_wready;
    assign r_fire     = bus.m_axi_rvalid && bus.m_axi_rready;
    assign r_beat_err = (bus.m_axi_rresp != 2'b00) || (bus.m_axi_rlast != last_beat);
    assign w_unused_ok = ^{bus.m_axi_bid, bus.m_axi_rid};

    assign bus.m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = len_q;
    assign bus.m_axi_awsize  = AXSIZE;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'b0011;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = (state_q == S_AW);

    assign bus.m_axi_wdata   = bus.s_wr_data;
    assign bus.m_axi_wstrb   = {STRB_WIDTH{1'b1}};
    assign bus.m_axi_wlast   = (state_q == S_W) && last_beat;
    assign bus.m_axi_wvalid  = (state_q == S_W) && bus.s_wr_valid;
    assign bus.s_wr_ready    = (state_q == S_W) && bus.m_axi_wready;
    assign bus.m_axi_bready  = (state_q == S_B);

    assign bus.m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = len_q;
    assign bus.m_axi_arsize  = AXSIZE;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = (state_q == S_AR);

    assign bus.m_axi_rready  = (state_q == S_R) && bus.m_rd_ready;
    assign bus.m_rd_valid    = (state_q == S_R) && bus.m_axi_rvalid;
    assign bus.m_rd_data     = bus.m_axi_rdata;
    assign bus.m_rd_last     = (state_q == S_R) && last_beat;

    assign bus.done  = done_q;
    assign bus.error = error_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        error_d  = error_q;
        rd_err_d = rd_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    addr_d   = bus.cmd_addr;
                    len_d    = bus.cmd_len;
                    cnt_d    = 8'd0;
                    rd_err_d = 1'b0;
                    state_d  = bus.cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: if (bus.m_axi_awready) state_d = S_W;
            S_W: begin
                if (w_fire) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) state_d = S_B;
                end
            end
            S_B: begin
                if (bus.m_axi_bvalid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = (bus.m_axi_bresp != 2'b00);
                end
            end
            S_AR: if (bus.m_axi_arready) state_d = S_R;
            S_R: begin
                if (r_fire) begin
                    cnt_d = cnt_q + 8'd1;
                    // Either an rlast or the expected final beat closes the burst.
                    if (bus.m_axi_rlast || last_beat) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        error_d = rd_err_q || r_beat_err;
                    end else begin
                        rd_err_d = rd_err_q || r_beat_err;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= 8'd0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            error_q  <= error_d;
            rd_err_q <= rd_err_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_axi_mem_loader.sv
// ============================================================================
// tb_axi_mem_loader : directed self-checking bench for axi_mem_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_mem_loader_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();

    axi_mem_loader #(
        .DATA_WIDTH(64), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [15:0] a, input logic [7:0] l, input logic w);
        int n = 0;
        bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_write = w; bus.cmd_valid = 1'b1;
        #1;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick(); #1; n++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL cmd_accept: cmd_ready=%b want 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); #1;
        n_cmp++;
        if ({bus.cmd_ready, bus.done, bus.error, bus.m_axi_awvalid, bus.m_axi_arvalid,
             bus.s_wr_ready, bus.m_rd_valid, bus.m_axi_rready} !== 8'b0) begin
            n_err++; $display("FAIL reset_outputs: cmd_ready=%b done=%b error=%b want all 0",
                              bus.cmd_ready, bus.done, bus.error);
        end
        rst = 1'b0;
        tick(); #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        issue_cmd(16'h0100, 8'd3, 1'b1);
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b1;
        bus.s_wr_valid = 1'b1; bus.s_wr_data = 64'h0;
        #1;
        n_cmp++;
        if ({bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize,
             bus.m_axi_awburst, bus.m_axi_awlock, bus.m_axi_awcache, bus.m_axi_awprot,
             bus.m_axi_awid} !== {1'b1, 16'h0100, 8'd3, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 8'd0}) begin
            n_err++; $display("FAIL wr_aw_fields: addr=%h len=%0d size=%0d valid=%b want 0100/3/3/1",
                              bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awvalid);
        end
        n_cmp++;
        if ({bus.m_axi_wvalid, bus.s_wr_ready} !== 2'b00) begin
            n_err++; $display("FAIL wr_w_before_aw: wvalid=%b s_wr_ready=%b want 0 0",
                              bus.m_axi_wvalid, bus.s_wr_ready);
        end
        bus.m_axi_awready = 1'b1;
        tick();
        bus.m_axi_awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.s_wr_data = 64'hD000 + 64'(i);
            #1;
            n_cmp++;
            if ({bus.m_axi_wvalid, bus.s_wr_ready, bus.m_axi_wdata, bus.m_axi_wlast, bus.m_axi_wstrb}
                !== {1'b1, 1'b1, 64'hD000 + 64'(i), (i == 3), 8'hFF}) begin
                n_err++; $display("FAIL wr_beat%0d: wvalid=%b data=%h wlast=%b strb=%h want 1/%h/%b/ff",
                                  i, bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wlast,
                                  bus.m_axi_wstrb, 64'hD000 + 64'(i), (i == 3));
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({bus.m_axi_wvalid, bus.s_wr_ready, bus.m_axi_bready} !== 3'b001) begin
            n_err++; $display("FAIL wr_in_b: wvalid=%b s_wr_ready=%b bready=%b want 0 0 1",
                              bus.m_axi_wvalid, bus.s_wr_ready, bus.m_axi_bready);
        end
        bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00;
        tick();
        bus.m_axi_bvalid = 1'b0; bus.s_wr_valid = 1'b0;
        #1;
        n_cmp++;
        if ({bus.done, bus.error, bus.cmd_ready} !== 3'b100) begin
            n_err++; $display("FAIL wr_done: done=%b error=%b cmd_ready=%b want 1 0 0",
                              bus.done, bus.error, bus.cmd_ready);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.done, bus.cmd_ready} !== 2'b01) begin
            n_err++; $display("FAIL wr_after_done: done=%b cmd_ready=%b want 0 1", bus.done, bus.cmd_ready);
        end
    endtask

    task automatic test_read_toggle();
        int   k = 0;
        logic rdy = 1'b0;
        issue_cmd(16'h0200, 8'd7, 1'b0);
        #1;
        n_cmp++;
        if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst}
            !== {1'b1, 16'h0200, 8'd7, 3'd3, 2'b01}) begin
            n_err++; $display("FAIL rd_ar_fields: valid=%b addr=%h len=%0d size=%0d want 1/0200/7/3",
                              bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize);
        end
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_arready = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            bus.m_axi_rvalid = 1'b1; bus.m_axi_rresp = 2'b00;
            bus.m_axi_rdata = 64'hA000 + 64'(k); bus.m_axi_rlast = (k == 7);
            bus.m_rd_ready = rdy;
            #1;
            if (rdy) begin
                n_cmp++;
                if ({bus.m_axi_rready, bus.m_rd_valid, bus.m_rd_data, bus.m_rd_last}
                    !== {1'b1, 1'b1, 64'hA000 + 64'(k), (k == 7)}) begin
                    n_err++; $display("FAIL rd_beat%0d: rready=%b valid=%b data=%h last=%b want 1/1/%h/%b",
                                      k, bus.m_axi_rready, bus.m_rd_valid, bus.m_rd_data,
                                      bus.m_rd_last, 64'hA000 + 64'(k), (k == 7));
                end
                k++;
            end else begin
                n_cmp++;
                if (bus.m_axi_rready !== 1'b0) begin
                    n_err++; $display("FAIL rd_stall%0d: rready=%b want 0", k, bus.m_axi_rready);
                end
            end
            tick();
            rdy = ~rdy;
        end
        n_cmp++;
        if (k !== 8) begin
            n_err++; $display("FAIL rd_beat_count: got %0d want 8", k);
        end
        bus.m_rd_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.done, bus.error, bus.m_axi_rready, bus.m_rd_valid} !== 4'b1000) begin
            n_err++; $display("FAIL rd_done: done=%b error=%b rready=%b m_rd_valid=%b want 1 0 0 0",
                              bus.done, bus.error, bus.m_axi_rready, bus.m_rd_valid);
        end
        tick();
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    endtask

    task automatic test_bresp_then_read();
        issue_cmd(16'h0010, 8'd0, 1'b1);
        bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
        #1;
        tick();
        bus.m_axi_awready = 1'b0;
        bus.s_wr_valid = 1'b1; bus.s_wr_data = 64'hBEEF;
        #1;
        n_cmp++;
        if ({bus.m_axi_wvalid, bus.m_axi_wlast} !== 2'b11) begin
            n_err++; $display("FAIL len0_wlast: wvalid=%b wlast=%b want 1 1", bus.m_axi_wvalid, bus.m_axi_wlast);
        end
        tick();
        bus.s_wr_valid = 1'b0; bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b10;
        #1;
        tick();
        bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
        #1;
        n_cmp++;
        if ({bus.done, bus.error} !== 2'b11) begin
            n_err++; $display("FAIL bresp_err: done=%b error=%b want 1 1", bus.done, bus.error);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.done, bus.error} !== 2'b01) begin
            n_err++; $display("FAIL error_hold: done=%b error=%b want 0 1", bus.done, bus.error);
        end
        issue_cmd(16'h0020, 8'd0, 1'b0);
        bus.m_axi_arready = 1'b1;
        #1;
        tick();
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 64'h5A5A; bus.m_axi_rlast = 1'b1;
        bus.m_axi_rresp = 2'b00; bus.m_rd_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.m_rd_valid, bus.m_rd_data, bus.m_rd_last} !== {1'b1, 64'h5A5A, 1'b1}) begin
            n_err++; $display("FAIL len0_rd: valid=%b data=%h last=%b want 1/5a5a/1",
                              bus.m_rd_valid, bus.m_rd_data, bus.m_rd_last);
        end
        tick();
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
        #1;
        n_cmp++;
        if ({bus.done, bus.error} !== 2'b10) begin
            n_err++; $display("FAIL rd_clears_err: done=%b error=%b want 1 0", bus.done, bus.error);
        end
        tick();
    endtask

    task automatic test_read_errors();
        // rlast arrives on beat 2 of a 4-beat read
        issue_cmd(16'h0600, 8'd3, 1'b0);
        bus.m_axi_arready = 1'b1;
        #1;
        tick();
        bus.m_axi_arready = 1'b0;
        bus.m_rd_ready = 1'b1; bus.m_axi_rvalid = 1'b1; bus.m_axi_rresp = 2'b00;
        for (int k = 0; k < 2; k++) begin
            bus.m_axi_rdata = 64'hE000 + 64'(k); bus.m_axi_rlast = (k == 1);
            #1;
            tick();
        end
        #1;
        n_cmp++;
        if ({bus.done, bus.error, bus.m_axi_rready, bus.m_rd_valid} !== 4'b1100) begin
            n_err++; $display("FAIL early_rlast: done=%b error=%b rready=%b m_rd_valid=%b want 1 1 0 0",
                              bus.done, bus.error, bus.m_axi_rready, bus.m_rd_valid);
        end
        tick(); #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL early_rlast_idle: cmd_ready=%b want 1", bus.cmd_ready);
        end
        // final expected beat without rlast
        issue_cmd(16'h0700, 8'd1, 1'b0);
        bus.m_axi_arready = 1'b1;
        #1;
        tick();
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rlast = 1'b0;
        #1;
        tick();
        #1;
        n_cmp++;
        if (bus.m_rd_last !== 1'b1) begin
            n_err++; $display("FAIL missing_rlast_mlast: m_rd_last=%b want 1", bus.m_rd_last);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.done, bus.error, bus.m_axi_rready} !== 3'b110) begin
            n_err++; $display("FAIL missing_rlast: done=%b error=%b rready=%b want 1 1 0",
                              bus.done, bus.error, bus.m_axi_rready);
        end
        bus.m_axi_rvalid = 1'b0;
        tick();
        // rresp error on the first beat only must survive to done
        issue_cmd(16'h0800, 8'd2, 1'b0);
        bus.m_axi_arready = 1'b1;
        #1;
        tick();
        bus.m_axi_arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.m_axi_rvalid = 1'b1; bus.m_axi_rresp = (k == 0) ? 2'b10 : 2'b00;
            bus.m_axi_rlast = (k == 2);
            #1;
            tick();
        end
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
        #1;
        n_cmp++;
        if ({bus.done, bus.error} !== 2'b11) begin
            n_err++; $display("FAIL sticky_rresp: done=%b error=%b want 1 1", bus.done, bus.error);
        end
        tick();
    endtask

    task automatic test_reset_midburst();
        issue_cmd(16'h0400, 8'd5, 1'b1);
        bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
        bus.s_wr_valid = 1'b1; bus.s_wr_data = 64'h77;
        #1;
        tick();
        #1;
        tick();
        #1;
        n_cmp++;
        if (bus.m_axi_wvalid !== 1'b1) begin
            n_err++; $display("FAIL midburst_pre: wvalid=%b want 1", bus.m_axi_wvalid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.s_wr_ready, bus.cmd_ready,
             bus.done, bus.error, bus.m_axi_bready} !== 7'b0) begin
            n_err++; $display("FAIL async_reset: awvalid=%b wvalid=%b s_wr_ready=%b cmd_ready=%b want 0",
                              bus.m_axi_awvalid, bus.m_axi_wvalid, bus.s_wr_ready, bus.cmd_ready);
        end
        tick();
        rst = 1'b0; bus.s_wr_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: cmd_ready=%b want 1", bus.cmd_ready);
        end
        issue_cmd(16'h0500, 8'd0, 1'b1);
        #1;
        n_cmp++;
        if ({bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen} !== {1'b1, 16'h0500, 8'd0}) begin
            n_err++; $display("FAIL post_reset_aw: valid=%b addr=%h len=%0d want 1/0500/0",
                              bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen);
        end
        tick();
        bus.m_axi_awready = 1'b0;
        bus.s_wr_valid = 1'b1; bus.s_wr_data = 64'h1234;
        #1;
        n_cmp++;
        if ({bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wlast} !== {1'b1, 64'h1234, 1'b1}) begin
            n_err++; $display("FAIL post_reset_w: wvalid=%b data=%h wlast=%b want 1/1234/1",
                              bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wlast);
        end
        tick();
        bus.s_wr_valid = 1'b0; bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00;
        #1;
        tick();
        bus.m_axi_bvalid = 1'b0;
        #1;
        n_cmp++;
        if ({bus.done, bus.error} !== 2'b10) begin
            n_err++; $display("FAIL post_reset_done: done=%b error=%b want 1 0", bus.done, bus.error);
        end
        tick();
    endtask

    task automatic test_stall();
        issue_cmd(16'h0300, 8'd2, 1'b1);
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b1; bus.s_wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen} !== {1'b1, 16'h0300, 8'd2}) begin
                n_err++; $display("FAIL aw_hold%0d: valid=%b addr=%h len=%0d want 1/0300/2",
                                  i, bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen);
            end
            tick();
        end
        bus.m_axi_awready = 1'b1;
        #1;
        tick();
        bus.m_axi_awready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.s_wr_valid = 1'b1; bus.s_wr_data = 64'hC0DE_0000 + 64'(b);
            #1;
            n_cmp++;
            if ({bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wlast}
                !== {1'b1, 64'hC0DE_0000 + 64'(b), (b == 2)}) begin
                n_err++; $display("FAIL stall_beat%0d: wvalid=%b data=%h wlast=%b want 1/%h/%b",
                                  b, bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wlast,
                                  64'hC0DE_0000 + 64'(b), (b == 2));
            end
            tick();
            if (b < 2) begin
                bus.s_wr_valid = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    #1;
                    n_cmp++;
                    if ({bus.m_axi_wvalid, bus.m_axi_wlast} !== {1'b0, (b == 1)}) begin
                        n_err++; $display("FAIL stall_gap%0d_%0d: wvalid=%b wlast=%b want 0 %b",
                                          b, s, bus.m_axi_wvalid, bus.m_axi_wlast, (b == 1));
                    end
                    tick();
                end
            end
        end
        bus.s_wr_valid = 1'b0; bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00;
        #1;
        tick();
        bus.m_axi_bvalid = 1'b0;
        #1;
        n_cmp++;
        if ({bus.done, bus.error} !== 2'b10) begin
            n_err++; $display("FAIL stall_done: done=%b error=%b want 1 0", bus.done, bus.error);
        end
        tick();
    endtask

    initial begin
        bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_write = 1'b0; bus.cmd_valid = 1'b0;
        bus.s_wr_data = '0; bus.s_wr_valid = 1'b0; bus.m_rd_ready = 1'b0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
        bus.m_axi_bid = '0; bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;

        test_reset();
        test_write_basic();
        test_read_toggle();
        test_bresp_then_read();
        test_read_errors();
        test_reset_midburst();
        test_stall();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
